// File: rtl/tron_isa_pkg.sv
//------------------------------------------------------------------------------
// Module : tron_isa_pkg
// Shared ISA definitions: instruction field positions and opcode encodings.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tron_isa_pkg;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int RDEST_HI = 11;
  localparam int RDEST_LO = 8;
  localparam int EXT_HI   = 7;
  localparam int EXT_LO   = 4;
  localparam int RSRC_HI  = 3;
  localparam int RSRC_LO  = 0;
  localparam int IMM8_HI  = 7;
  localparam int IMM8_LO  = 0;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'h0,
    OP_ANDI  = 4'h1,
    OP_ORI   = 4'h2,
    OP_XORI  = 4'h3,
    OP_MEM   = 4'h4,
    OP_ADDI  = 4'h5,
    OP_SUBI  = 4'h9,
    OP_CMPI  = 4'hB,
    OP_BCOND = 4'hC,
    OP_MOVI  = 4'hD,
    OP_LUI   = 4'hF
  } opcode_e;

endpackage

`default_nettype wire

// File: rtl/instr_queue_mem.sv
//------------------------------------------------------------------------------
// Module : instr_queue_mem
// DEPTH x WIDTH register file: synchronous write, combinational read, no reset.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_queue_mem #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/instr_queue.sv
//------------------------------------------------------------------------------
// Module : instr_queue
// DEPTH-entry instruction queue between MDR and decode, with flush and decoded
// head fields.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_queue
  import tron_isa_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  MDR_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  IR_out,
  output logic [3:0]        opcode,
  output logic [3:0]        rdest,
  output logic [3:0]        op_ext,
  output logic [3:0]        rsrc,
  output logic [7:0]        imm8,
  output logic [ADDR_W:0]   count
);

  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  occupancy;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             mem_we;
  logic [WIDTH-1:0] head_word;

  // Extra pointer MSB separates full (addresses equal, laps differ) from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A push coinciding with flush or reset is dropped, so it must not touch storage.
  assign mem_we = push && !flush && !reset;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        occupancy <= occupancy + 1'b1;
      end else if (pop && !push) begin
        occupancy <= occupancy - 1'b1;
      end
    end
  end

  instr_queue_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (MDR_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (head_word)
  );

  assign IR_out = out_valid ? head_word : '0;
  assign count  = occupancy;

  assign opcode = IR_out[OPC_HI:OPC_LO];
  assign rdest  = IR_out[RDEST_HI:RDEST_LO];
  assign op_ext = IR_out[EXT_HI:EXT_LO];
  assign rsrc   = IR_out[RSRC_HI:RSRC_LO];
  assign imm8   = IR_out[IMM8_HI:IMM8_LO];

endmodule

`default_nettype wire

// File: tb/tb_instr_queue.sv
//------------------------------------------------------------------------------
// Module : tb_instr_queue
// Directed self-checking bench for instr_queue (DEPTH = 4).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_queue;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  MDR_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  IR_out;
  logic [3:0]        opcode;
  logic [3:0]        rdest;
  logic [3:0]        op_ext;
  logic [3:0]        rsrc;
  logic [7:0]        imm8;
  logic [ADDR_W:0]   count;

  int checks = 0;
  int errors = 0;

  instr_queue #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .MDR_data  (MDR_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .IR_out    (IR_out),
    .opcode    (opcode),
    .rdest     (rdest),
    .op_ext    (op_ext),
    .rsrc      (rsrc),
    .imm8      (imm8),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; all checked outputs depend on registered state only.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; MDR_data = 16'h5555; out_ready = 1'b0;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (IR_out !== 16'h0000) begin errors++; $display("FAIL reset_IR_out: got %h expected 0000", IR_out); end
  endtask

  task automatic test_single_push();
    MDR_data = 16'h1234; in_valid = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nobypass_out_valid: got %b expected 0", out_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (IR_out !== 16'h1234) begin errors++; $display("FAIL single_IR_out: got %h expected 1234", IR_out); end
    checks++; if (opcode !== 4'h1) begin errors++; $display("FAIL single_opcode: got %h expected 1", opcode); end
    checks++; if (rdest !== 4'h2) begin errors++; $display("FAIL single_rdest: got %h expected 2", rdest); end
    checks++; if (op_ext !== 4'h3) begin errors++; $display("FAIL single_op_ext: got %h expected 3", op_ext); end
    checks++; if (rsrc !== 4'h4) begin errors++; $display("FAIL single_rsrc: got %h expected 4", rsrc); end
    checks++; if (imm8 !== 8'h34) begin errors++; $display("FAIL single_imm8: got %h expected 34", imm8); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_pop_count: got %0d expected 0", count); end
    checks++; if (IR_out !== 16'h0000) begin errors++; $display("FAIL single_empty_IR_out: got %h expected 0000", IR_out); end
  endtask

  task automatic test_fill();
    logic [15:0] exp;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      MDR_data = 16'hA000 + 16'(i); in_valid = 1'b1;
      tick();
      if (i == 4) begin
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count4: got %0d expected 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
      end
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_overflow_count: got %0d expected 4", count); end
    for (int i = 1; i <= 4; i++) begin
      exp = 16'hA000 + 16'(i);
      checks++; if (IR_out !== exp) begin errors++; $display("FAIL drain_order%0d: got %h expected %h", i, IR_out, exp); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got out_valid %b expected 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 1; i <= 2; i++) begin
      MDR_data = 16'hB000 + 16'(i); in_valid = 1'b1;
      tick();
    end
    // Pointers start near the top of the address range, so this run wraps.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      MDR_data = 16'hB003 + 16'(k);
      exp = 16'hB001 + 16'(k);
      checks++; if (IR_out !== exp) begin errors++; $display("FAIL b2b_head%0d: got %h expected %h", k, IR_out, exp); end
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d expected 2", k, count); end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp = 16'hB007 + 16'(k);
      checks++; if (IR_out !== exp) begin errors++; $display("FAIL b2b_tail%0d: got %h expected %h", k, IR_out, exp); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_final_count: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      MDR_data = 16'hC000 + 16'(i); in_valid = 1'b1;
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    flush = 1'b1; MDR_data = 16'hC004; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    MDR_data = 16'hBEEF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (IR_out !== 16'hBEEF) begin errors++; $display("FAIL flush_head: got %h expected beef", IR_out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_push_count: got %0d expected 1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    for (int i = 1; i <= 3; i++) begin
      MDR_data = 16'hD000 + 16'(i); in_valid = 1'b1;
      tick();
    end
    reset = 1'b1; MDR_data = 16'hD004; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    checks++; if ({IR_out, opcode, rdest, op_ext, rsrc, imm8} !== 40'h0) begin
      errors++; $display("FAIL midrst_outputs: got IR_out %h imm8 %h expected 0", IR_out, imm8);
    end
    MDR_data = 16'hE123; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (IR_out !== 16'hE123) begin errors++; $display("FAIL midrst_resume: got %h expected e123", IR_out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL midrst_resume_count: got %0d expected 1", count); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; MDR_data = '0;
    tick();
    tick();
    test_reset();
    test_single_push();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule

`default_nettype wire
